// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared types and defaults for the counter scheduler.
//   sched_state_t : scheduler FSM state encoding (IDLE, RUN, DONE)
//   NREQ_DEF      : default number of requesters
//   CNT_W_DEF     : default counter / length width
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int NREQ_DEF  = 4;
  localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req         : request levels, one bit per requester
//   pointer     : last granted index; search starts at pointer+1 (mod NREQ)
//   grant_valid : at least one request is high
//   grant_idx   : chosen requester (0 when grant_valid is low)
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  pointer,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_idx
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester after
  // the pointer is the last assignment and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = (int'(pointer) + off) % NREQ;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// counter_sched: time-shares one up-counter between NREQ requesters.
// A round-robin arbiter picks a requester in IDLE, the counter runs 0..len,
// and the granted requester gets a one-cycle done pulse.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   req        : per-requester request level (sampled only in IDLE)
//   len        : per-requester terminal value, requester i at [i*CNT_W +: CNT_W]
//   busy       : high in RUN and DONE
//   grant_id   : current / last granted requester
//   count      : shared counter value
//   done       : one-hot one-cycle completion pulse
//   wrap       : pulse with done when the run ended at all-ones
// Optional (macro COUNTER_SCHED_ABORT_EN):
//   abort      : cancels an active run (ignored outside RUN)
//   aborted    : one-hot one-cycle pulse to the cancelled requester
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] len,
`ifdef COUNTER_SCHED_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic [CNT_W-1:0]      count,
  output logic [NREQ-1:0]       done,
`ifdef COUNTER_SCHED_ABORT_EN
  output logic [NREQ-1:0]       aborted,
`endif
  output logic                  wrap
);

  logic [NREQ-1:0][CNT_W-1:0] len_a;
  assign len_a = len;

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [NREQ-1:0]  abt_q, abt_d;
  logic             abort_i;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;

`ifdef COUNTER_SCHED_ABORT_EN
  assign abort_i = abort;
  assign aborted = abt_q;
`else
  assign abort_i = 1'b0;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req         (req),
    .pointer     (ptr_q),
    .grant_valid (gnt_vld),
    .grant_idx   (gnt_idx)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    done_d   = '0;
    wrap_d   = 1'b0;
    abt_d    = '0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (gnt_vld) begin
          target_d = len_a[gnt_idx];
          gid_d    = gnt_idx;
          ptr_d    = gnt_idx;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Abort wins over completion; pointer stays on the cancelled grant.
        if (abort_i) begin
          count_d       = '0;
          abt_d[gid_q]  = 1'b1;
          state_d       = IDLE;
        end else if (count_q == target_q) begin
          count_d       = '0;
          done_d[gid_q] = 1'b1;
          wrap_d        = &target_q;
          state_d       = DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      target_q <= '0;
      gid_q    <= '0;
      ptr_q    <= IDW'(NREQ - 1);
      done_q   <= '0;
      wrap_q   <= 1'b0;
      abt_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      abt_q    <= abt_d;
    end
  end

  assign busy     = (state_q == RUN) || (state_q == DONE);
  assign grant_id = gid_q;
  assign count    = count_q;
  assign done     = done_q;
  assign wrap     = wrap_q;

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Time-shares one 4-bit up-counter datapath between NREQ requesters.
- Each requester asks for a count of LEN cycles. A round-robin arbiter grants one requester at a time, the shared counter runs 0..LEN, and the granted requester receives a one-cycle done pulse.
- Sits between the 4-bit counter datapath and the blocks that need timed delays.

Parameters:
- NREQ, 4: number of requesters (2..8).
- CNT_W, 4: counter width. len and count use this width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request level
- len  input  NREQ*CNT_W  per-requester terminal value; requester i uses bits [i*CNT_W +: CNT_W]
- busy  output  1  high in RUN and DONE states
- grant_id  output  $clog2(NREQ)  index of the current or last granted requester
- count  output  CNT_W  shared counter value
- done  output  NREQ  one-hot, one-cycle completion pulse
- wrap  output  1  one-cycle pulse when a run terminates at count == all-ones

Behaviour:
- Reset (asynchronous, active-high) forces all of the following immediately and regardless of clk:
  - state = IDLE
  - count = 0, done = 0, wrap = 0, busy = 0, grant_id = 0
  - round-robin pointer = NREQ-1, so requester 0 has first priority
- Reset mid-run abandons the run. No done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is high at the clock edge, select the first requester searching from pointer+1 upward, modulo NREQ.
  - On that edge: latch target = len[g], set grant_id = g, update pointer = g, set count = 0, go to RUN.
  - If no req bit is high, stay in IDLE with count = 0.
- RUN:
  - Each edge, if count != target, then count = count + 1.
  - If count == target: go to DONE, count = 0, done[grant_id] = 1 in the DONE cycle, and wrap = 1 if target == all-ones.
  - The counter never overflows past target. all-ones followed by 0 is the only wrap path.
- DONE: lasts exactly one cycle, then IDLE. done and wrap return to 0.
- Latency: req sampled at edge E0 puts count at 0 after E0. With target L, done is high in the cycle following edge E0+L+1. The run occupies L+1 cycles in RUN.
  - L = 0: one RUN cycle, then done.
  - L = 15: 16 RUN cycles, then done and wrap together.
- req and len are sampled only in IDLE.
  - Changes to len during RUN do not affect the active run.
  - Deasserting req during RUN does not cancel the run; done still pulses.
- A requester must drop req in the cycle done is seen, or it re-requests.
- Fairness: after a grant to g, g has lowest priority at the next arbitration. With all req held high, grants rotate 0,1,2,3,0,...
- Back-to-back runs: DONE→IDLE→RUN, so there is a minimum 2-cycle gap between the last RUN cycle of one run and count=0 of the next.
- done is one-hot or zero. wrap is never high without done.

Optional Feature:
- Macro: COUNTER_SCHED_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort high at an edge while in RUN forces: count = 0, next state IDLE, no done or wrap pulse, pointer kept at the aborted g.
  - abort is ignored in IDLE and DONE.
  - Adds output aborted (NREQ, one-hot one-cycle pulse to the cancelled requester in the cycle after abort).
- When not defined: no abort or aborted port. Every granted run completes.

Decomposition:
- Package counter_sched_pkg holds:
  - state enum sched_state_t {IDLE, RUN, DONE}
  - localparam defaults for CNT_W and NREQ
- Sub-module rr_arbiter (NREQ param) is the natural split: purely combinational.
  - Inputs: req, pointer.
  - Outputs: grant_valid, grant_idx.
- Counter, FSM and pointer register stay in counter_sched.

Test Plan:
- Reset mid-RUN: req[0]=1, len0=5, assert reset at count=3 → count, busy, done go to 0 immediately; IDLE after release; no done[0] pulse.
- Single request: req[2]=1, len2=3 → count goes 0,1,2,3; done=4'b0100 for one cycle; grant_id=2; wrap=0; busy low afterwards.
- Boundary lengths:
  - len=0 → done after one RUN cycle with count=0.
  - len=15 → count goes 0..15; done and wrap both high in the same cycle; count=0 in DONE.
- Round-robin: all four req held high, each len=1 → done order 0001, 0010, 0100, 1000, 0001; 2-cycle gap between RUN phases.
- Mid-run changes: during req[1] run with len1=6, change len1 to 2 and drop req[1] at count=1 → run still completes to count 6, then done[1].
- Abort (macro defined): req[3]=1, len3=10, abort at count=4 → aborted=4'b1000 the next cycle; done stays 0; count=0; IDLE; next grant searches from 0.
